// File: rtl/cpu1_core.sv
// Second-generation accumulator CPU: internal program RAM, 3-bit opcodes, Z/C flags, run/halt control.
// Optional breakpoint support is enabled with the CPU1_BREAKPOINT_EN macro.
module cpu1_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  localparam int unsigned IW = 3 + ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [IW-1:0]     prog_data,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
`ifdef CPU1_BREAKPOINT_EN
  ,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_e;
  typedef enum logic [2:0] {
    OP_ADDI = 3'b000,
    OP_ANDI = 3'b001,
    OP_JP   = 3'b010,
    OP_INC  = 3'b011,
    OP_JZ   = 3'b100,
    OP_JC   = 3'b101,
    OP_LDI  = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic                halted_q, halted_d;
  logic [IW-1:0]       mem_q [DEPTH];
`ifdef CPU1_BREAKPOINT_EN
  logic                skip_q, skip_d;
`endif

  op_e                 op_c;
  logic [ADDR_W-1:0]   operand_c;
  logic [DATA_W-1:0]   imm_c;
  logic [DATA_W:0]     add_sum_c;
  logic [DATA_W:0]     inc_sum_c;
  logic                mem_we_c;

  assign op_c      = op_e'(ir_q[IW-1:ADDR_W]);
  assign operand_c = ir_q[ADDR_W-1:0];
  assign imm_c     = DATA_W'(operand_c);
  assign add_sum_c = {1'b0, acc_q} + {1'b0, imm_c};
  assign inc_sum_c = {1'b0, acc_q} + (DATA_W+1)'(1);
  assign mem_we_c  = prog_we && (state_q == S_IDLE);

  // Program RAM has no reset so its contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      acc_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      ir_q     <= '0;
      halted_q <= 1'b1;
`ifdef CPU1_BREAKPOINT_EN
      skip_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      c_q      <= c_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
`ifdef CPU1_BREAKPOINT_EN
      skip_q   <= skip_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    z_d     = z_q;
    c_d     = c_q;
    ir_d    = ir_q;
`ifdef CPU1_BREAKPOINT_EN
    skip_d  = skip_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
`ifdef CPU1_BREAKPOINT_EN
          skip_d  = 1'b1;
`endif
        end
      end
      S_FETCH: begin
        ir_d    = mem_q[pc_q];
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
`ifdef CPU1_BREAKPOINT_EN
        // Breakpoint stops before fetching; the first fetch after a run is exempt.
        skip_d = 1'b0;
        if (bp_en && (pc_q == bp_addr) && !skip_q) begin
          ir_d    = ir_q;
          pc_d    = pc_q;
          state_d = S_IDLE;
        end
`endif
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_c)
          OP_ADDI: begin
            {c_d, acc_d} = add_sum_c;
            z_d          = (add_sum_c[DATA_W-1:0] == '0);
          end
          OP_ANDI: begin
            acc_d = acc_q & imm_c;
            z_d   = ((acc_q & imm_c) == '0);
            c_d   = 1'b0;
          end
          OP_JP:   pc_d = operand_c;
          OP_INC: begin
            {c_d, acc_d} = inc_sum_c;
            z_d          = (inc_sum_c[DATA_W-1:0] == '0);
          end
          OP_JZ:   if (z_q) pc_d = operand_c;
          OP_JC:   if (c_q) pc_d = operand_c;
          OP_LDI: begin
            acc_d = imm_c;
            z_d   = (imm_c == '0);
          end
          OP_HALT: state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    halted_d = (state_d == S_IDLE);
  end

  assign acc_out = acc_q;
  assign pc_out  = pc_q;
  assign flag_z  = z_q;
  assign flag_c  = c_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_cpu1_core.sv
// Scoreboard bench for cpu1_core: expected architectural state is queued with each stimulus
// and popped when the CPU reaches the corresponding observation point.
module tb_cpu1_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned IW     = 3 + ADDR_W;

  localparam logic [2:0] ADDI = 3'b000, ANDI = 3'b001, JP = 3'b010, INC = 3'b011;
  localparam logic [2:0] JZ = 3'b100, JC = 3'b101, LDI = 3'b110, HALT = 3'b111;

  typedef struct packed {
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] pc;
    logic              z;
    logic              c;
    logic              halted;
  } obs_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              run = 1'b0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [IW-1:0]     prog_data = '0;
  logic [DATA_W-1:0] acc_out;
  logic [ADDR_W-1:0] pc_out;
  logic              flag_z, flag_c, halted;
`ifdef CPU1_BREAKPOINT_EN
  logic              bp_en = 1'b0;
  logic [ADDR_W-1:0] bp_addr = '0;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  obs_t exp_q[$];
  obs_t got, exp;

  cpu1_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .acc_out(acc_out), .pc_out(pc_out), .flag_z(flag_z), .flag_c(flag_c),
    .halted(halted)
`ifdef CPU1_BREAKPOINT_EN
    , .bp_en(bp_en), .bp_addr(bp_addr)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] ins(input logic [2:0] op, input logic [ADDR_W-1:0] a);
    return {op, a};
  endfunction

  function automatic obs_t mk(input logic [DATA_W-1:0] a, input logic [ADDR_W-1:0] p,
                              input logic z, input logic c, input logic h);
    return {a, p, z, c, h};
  endfunction

  function automatic obs_t observe();
    return {acc_out, pc_out, flag_z, flag_c, halted};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("acc=%h pc=%0d z=%b c=%b halted=%b", o.acc, o.pc, o.z, o.c, o.halted);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    prog_we = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [IW-1:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we = 1'b1;
    tick();
    prog_we = 1'b0;
  endtask

  // Pulses run for one cycle, then counts cycles with halted low until the CPU halts.
  task automatic run_until_halt(input int budget, output int busy, output bit timed_out);
    run = 1'b1;
    tick();
    run = 1'b0;
    busy = 0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (halted) begin
        timed_out = 1'b0;
        break;
      end
      busy++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(8'h00, 6'd0, 1'b0, 1'b0, 1'b1));
      repeat (4) tick();
      got = observe();
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: got %s expected %s", k, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_addi();
    int busy;
    bit to;
    do_reset();
    load_word(6'd0, ins(LDI, 6'h3F));
    load_word(6'd1, ins(ADDI, 6'h3F));
    load_word(6'd2, ins(HALT, 6'h00));
    exp_q.push_back(mk(8'h7E, 6'd3, 1'b0, 1'b0, 1'b1));
    run_until_halt(50, busy, to);
    vectors++;
    if (to || busy !== 6) begin
      miscompares++;
      $display("FAIL addi_cycles: got busy=%0d timeout=%b expected busy=6 timeout=0", busy, to);
    end
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL addi_result: got %s expected %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_jz();
    int busy;
    bit to;
    do_reset();
    load_word(6'd0, ins(LDI, 6'h3F));
    load_word(6'd1, ins(ANDI, 6'h00));
    load_word(6'd2, ins(JZ, 6'd4));
    load_word(6'd3, ins(HALT, 6'h00));
    load_word(6'd4, ins(INC, 6'h00));
    load_word(6'd5, ins(HALT, 6'h00));
    exp_q.push_back(mk(8'h01, 6'd6, 1'b0, 1'b0, 1'b1));
    run_until_halt(80, busy, to);
    vectors++;
    if (to || busy !== 10) begin
      miscompares++;
      $display("FAIL jz_cycles: got busy=%0d timeout=%b expected busy=10 timeout=0", busy, to);
    end
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL jz_result: got %s expected %s", fmt(got), fmt(exp));
    end
  endtask

  task automatic test_carry();
    int busy;
    bit to;
    do_reset();
    load_word(6'd0, ins(LDI, 6'h3F));
    for (int a = 1; a <= 3; a++) load_word(6'(a), ins(ADDI, 6'h3F));
    load_word(6'd4, ins(ADDI, 6'h03));
    load_word(6'd5, ins(INC, 6'h00));
    load_word(6'd6, ins(JC, 6'd9));
    for (int a = 7; a <= 9; a++) load_word(6'(a), ins(HALT, 6'h00));
    exp_q.push_back(mk(8'h00, 6'd10, 1'b1, 1'b1, 1'b1));
    run_until_halt(100, busy, to);
    vectors++;
    if (to || busy !== 16) begin
      miscompares++;
      $display("FAIL carry_cycles: got busy=%0d timeout=%b expected busy=16 timeout=0", busy, to);
    end
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL carry_result: got %s expected %s", fmt(got), fmt(exp));
    end
  endtask

  // PC wrap 63->0, writes ignored while running, reset in the middle of EXEC.
  task automatic test_wrap_and_abort();
    do_reset();
    load_word(6'd0, ins(JP, 6'd63));
    load_word(6'd63, ins(INC, 6'h00));
    run = 1'b1;
    tick();
    run = 1'b0;
    prog_we = 1'b1;
    prog_addr = 6'd0;
    prog_data = ins(HALT, 6'h00);
    exp_q.push_back(mk(8'h01, 6'd0, 1'b0, 1'b0, 1'b0));
    repeat (4) tick();
    prog_we = 1'b0;
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL pc_wrap: got %s expected %s", fmt(got), fmt(exp));
    end
    tick();
    reset_n = 1'b0;
    exp_q.push_back(mk(8'h00, 6'd0, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_exec: got %s expected %s", fmt(got), fmt(exp));
    end
    reset_n = 1'b1;
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    exp_q.push_back(mk(8'h02, 6'd0, 1'b0, 1'b0, 1'b0));
    repeat (8) tick();
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL ram_unchanged: got %s expected %s", fmt(got), fmt(exp));
    end
    do_reset();
  endtask

  // Run held high: HALT spends one IDLE cycle, and a write in the run cycle still lands.
  task automatic test_back_to_back();
    do_reset();
    for (int a = 0; a <= 2; a++) load_word(6'(a), ins(HALT, 6'h00));
    prog_we = 1'b1;
    prog_addr = 6'd0;
    prog_data = ins(INC, 6'h00);
    run = 1'b1;
    tick();
    prog_we = 1'b0;
    exp_q.push_back(mk(8'h01, 6'd2, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h01, 6'd2, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h01, 6'd3, 1'b0, 1'b0, 1'b1));
    repeat (4) tick();
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL hold_run_halt: got %s expected %s", fmt(got), fmt(exp));
    end
    tick();
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL hold_run_restart: got %s expected %s", fmt(got), fmt(exp));
    end
    repeat (2) tick();
    run = 1'b0;
    tick();
    got = observe();
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL hold_run_final: got %s expected %s", fmt(got), fmt(exp));
    end
  endtask

`ifdef CPU1_BREAKPOINT_EN
  task automatic test_breakpoint();
    int busy;
    bit to;
    do_reset();
    for (int a = 0; a <= 2; a++) load_word(6'(a), ins(INC, 6'h00));
    load_word(6'd3, ins(HALT, 6'h00));
    bp_en = 1'b1;
    bp_addr = 6'd2;
    exp_q.push_back(mk(8'h02, 6'd2, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h03, 6'd4, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 2; k++) begin
      run_until_halt(50, busy, to);
      vectors++;
      if (to || busy !== (k == 0 ? 5 : 4)) begin
        miscompares++;
        $display("FAIL bp_cycles[%0d]: got busy=%0d timeout=%b expected busy=%0d", k, busy, to,
                 (k == 0 ? 5 : 4));
      end
      got = observe();
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL bp_result[%0d]: got %s expected %s", k, fmt(got), fmt(exp));
      end
    end
    bp_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_addi();
    test_jz();
    test_carry();
    test_wrap_and_abort();
    test_back_to_back();
`ifdef CPU1_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu1_core.md
Name: cpu1_core

Overview:
- Parametrised successor of the 2-opcode accumulator CPU.
- Configurable data width and program depth; 3-bit opcode set with immediate load, conditional jumps on Z/C flags and HALT.
- Host program-load port and run/halt control.
- Sits standalone under the top level as the team's second-generation toy CPU; program RAM is internal.

Parameters:
- DATA_W, 8, accumulator/ALU width; must be >= ADDR_W.
- ADDR_W, 6, PC and operand width; program depth = 2**ADDR_W words.
- IW, 3+ADDR_W, instruction width (derived localparam, not overridable): [IW-1:ADDR_W] opcode, [ADDR_W-1:0] operand.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- run  input  1  level-sampled in IDLE; starts/resumes execution.
- prog_we  input  1  program RAM write enable; honoured only in IDLE.
- prog_addr  input  ADDR_W  program RAM write address.
- prog_data  input  IW  program RAM write data.
- acc_out  output  DATA_W  accumulator.
- pc_out  output  ADDR_W  program counter.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry flag.
- halted  output  1  high while in IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pc=0, acc=0, flag_z=0, flag_c=0, halted=1. Program RAM is not cleared; contents survive reset.
- States: IDLE, FETCH, EXEC.
  - IDLE: halted=1. prog_we writes mem[prog_addr]<=prog_data. run=1 -> FETCH (prog_we in the same cycle still writes). pc unchanged.
  - FETCH: ir<=mem[pc]; pc<=pc+1 mod 2**ADDR_W (wraps max->0); -> EXEC. halted=0.
  - EXEC: decode ir; -> FETCH, except HALT -> IDLE.
- Every instruction takes exactly 2 cycles; the architectural update is visible on outputs the cycle after EXEC.
- imm = operand zero-extended to DATA_W.
- Opcodes:
  - 000 ADDI: {c,acc}<=acc+imm (DATA_W+1-bit sum); z<=(new acc==0).
  - 001 ANDI: acc<=acc&imm; z updated; c<=0.
  - 010 JP: pc<=operand; flags unchanged.
  - 011 INC: {c,acc}<=acc+1; z updated. All-ones wraps to 0 with c=1, z=1.
  - 100 JZ: if z, pc<=operand, else pc unchanged (already +1).
  - 101 JC: if c, pc<=operand, else pc unchanged.
  - 110 LDI: acc<=imm; z updated; c unchanged.
  - 111 HALT: -> IDLE; pc stays at HALT address+1; acc/flags unchanged.
- Resume: run high in IDLE continues from the current pc. If run is held high, HALT costs one IDLE cycle and execution then restarts immediately.
- prog_we outside IDLE is ignored; RAM is unchanged. Self-modification is impossible.
- Reset mid-instruction aborts immediately; the partial instruction has no effect beyond the reset values.

Optional Feature:
- Macro: CPU1_BREAKPOINT_EN.
- Defined:
  - Adds ports bp_en (input 1) and bp_addr (input ADDR_W).
  - In FETCH, if bp_en && pc==bp_addr: no fetch, pc unchanged, -> IDLE.
  - The next run from IDLE executes the instruction at bp_addr without rechecking the breakpoint; an internal skip flag is set on the IDLE->FETCH transition and cleared after one FETCH.
  - Reset clears the skip flag.
- Undefined: ports absent; FETCH always fetches.

Test Plan:
- Reset with run=0: acc=0, pc=0, z=0, c=0, halted=1 indefinitely.
- Load {LDI 0x3F, ADDI 0x3F, HALT} (DATA_W=8, ADDR_W=6), pulse run -> halted after 6 cycles, acc=0x7E, c=0, z=0, pc=3.
- Load {LDI 0x3F, ANDI 0x00, JZ 4, HALT, INC, HALT}, run -> acc=0x01, z=0, halted with pc=6; the HALT at address 3 is never reached.
- acc preset 0xFF by {LDI 0x3F, ADDI 0x3F, ADDI 0x3F, ADDI 0x3F, ADDI 0x03, INC, JC 9, ..., 9:HALT} -> after INC acc=0x00, z=1, c=1; JC taken, pc=10 at halt.
- Program word at address 63 = INC, JP 63 from address 0, run -> after INC, pc wraps to 0; prog_we pulsed while running leaves RAM unchanged (readback after halt); reset_n asserted mid-EXEC -> all outputs reset next cycle.
- With CPU1_BREAKPOINT_EN, bp_addr=2, program {INC, INC, INC, HALT}: halts with acc=2, pc=2; second run -> acc=3, halted at pc=4.
